// File: rtl/jk_bank_sequencer_if.sv
// Command channel into jk_bank_sequencer: valid/ready handshake carrying op, data, count,
// plus the abort that cancels a running multi-step command.
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNTW-1:0]  cmd_count;
    logic             abort;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, abort,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Sequences a WIDTH-bit bank of JK flip-flops from one command at a time, generating
// per-bit J/K drive and reporting completion (done) and counter wrap.
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_bank_sequencer_if.slave   cmd,
    output logic [WIDTH-1:0]     j_drv,
    output logic [WIDTH-1:0]     k_drv,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qb,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_CLEAR  = 3'b001,
        OP_SET    = 3'b010,
        OP_TOGGLE = 3'b011,
        OP_LOAD   = 3'b100,
        OP_UP     = 3'b101,
        OP_DOWN   = 3'b110,
        OP_HOLD   = 3'b111
    } op_t;

    localparam logic [WIDTH-1:0] ONES = '1;

    state_t           state;
    op_t              op;
    logic [WIDTH-1:0] data;
    logic [CNTW-1:0]  remaining;

    logic             multi;
    logic             stall;
    logic             new_multi;
    logic             wrap_next;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;

    assign multi     = op inside {OP_UP, OP_DOWN, OP_HOLD};
    assign new_multi = cmd.cmd_op inside {OP_UP, OP_DOWN, OP_HOLD};
    // abort only cancels count/hold; single-step ops always complete their edge
    assign stall     = (state == S_EXEC) && multi && cmd.abort;

    assign cmd.cmd_ready = (state == S_IDLE) && !rst;
    assign qb            = ~q;

    // Toggle enables for counting: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic up_c;
        logic dn_c;
        // NOTE: combinational blocks use blocking '=' and assign every output a default
        // first, so no path leaves a signal unassigned and no latch is inferred.
        up_c = 1'b1;
        dn_c = 1'b1;
        up_t = '0;
        dn_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = up_c;
            dn_t[i] = dn_c;
            up_c    = up_c & q[i];
            dn_c    = dn_c & qb[i];
        end
    end

    always_comb begin
        j_drv = '0;
        k_drv = '0;
        if (state == S_EXEC && !stall) begin
            case (op)
                OP_CLEAR:  begin j_drv = '0;    k_drv = ONES;  end
                OP_SET:    begin j_drv = ONES;  k_drv = '0;    end
                OP_TOGGLE: begin j_drv = data;  k_drv = data;  end
                OP_LOAD:   begin j_drv = data;  k_drv = ~data; end
                OP_UP:     begin j_drv = up_t;  k_drv = up_t;  end
                OP_DOWN:   begin j_drv = dn_t;  k_drv = dn_t;  end
                default:   begin j_drv = '0;    k_drv = '0;    end
            endcase
        end
    end

    assign wrap_next = (state == S_EXEC) && !stall &&
                       (((op == OP_UP) && (q == ONES)) || ((op == OP_DOWN) && (q == '0)));

    // NOTE: all state is updated with non-blocking '<=' so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op        <= OP_NOP;
            data      <= '0;
            remaining <= '0;
            q         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            // JK bank: 00 hold, 01 clear, 10 set, 11 toggle
            q    <= (j_drv & ~q) | (~k_drv & q);
            wrap <= wrap_next;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        op        <= op_t'(cmd.cmd_op);
                        data      <= cmd.cmd_data;
                        remaining <= new_multi ? cmd.cmd_count : CNTW'(1);
                        if (cmd.cmd_op == OP_NOP || (new_multi && cmd.cmd_count == '0)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_EXEC;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (stall || remaining == CNTW'(1)) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        remaining <= '0;
                    end else begin
                        remaining <= remaining - CNTW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: an arithmetic model of the bank predicts every
// output cycle by cycle, plus literal end-of-test expectations.
module tb_jk_bank_sequencer;
    localparam int WIDTH = 4;
    localparam int CNTW  = 8;

    localparam logic [2:0] NOP = 3'b000, CLEAR = 3'b001, SET = 3'b010, TOGGLE = 3'b011,
                           LOAD = 3'b100, UP = 3'b101, DOWN = 3'b110, HOLD = 3'b111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jk_bank_sequencer_if #(.WIDTH(WIDTH), .CNTW(CNTW)) cmd_if();

    logic [WIDTH-1:0] j_drv, k_drv, q, qb;
    logic             busy, done, wrap;

    jk_bank_sequencer #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cmd_if),
        .j_drv (j_drv),
        .k_drv (k_drv),
        .q     (q),
        .qb    (qb),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of what the outputs must be in the current cycle
    logic [3:0] m_q, m_qb, m_j, m_k;
    logic       m_busy, m_done, m_wrap, m_ready;
    bit         cmp_en = 0;
    int         done_pulses = 0;
    int         wrap_pulses = 0;

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (wrap) wrap_pulses++;
        if (cmp_en) begin
            m_qb = ~m_q;
            check("q", q, m_q);
            check("qb", qb, m_qb);
            check("j_drv", j_drv, m_j);
            check("k_drv", k_drv, m_k);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("wrap", wrap, m_wrap);
            check("cmd_ready", cmd_if.cmd_ready, m_ready);
        end
    end

    // One step of an op on the bank, expressed as its arithmetic effect; drive = bits that must change
    function automatic void model_step(input logic [2:0] op, input logic [3:0] qv, input logic [3:0] d,
                                       output logic [3:0] j, output logic [3:0] k, output logic [3:0] nq);
        case (op)
            CLEAR:   begin nq = 4'h0;          j = 4'h0; k = 4'hF; end
            SET:     begin nq = 4'hF;          j = 4'hF; k = 4'h0; end
            TOGGLE:  begin nq = qv ^ d;        j = d;    k = d;    end
            LOAD:    begin nq = d;             j = d;    k = ~d;   end
            UP:      begin nq = qv + 4'd1;     j = qv ^ nq; k = j; end
            DOWN:    begin nq = qv - 4'd1;     j = qv ^ nq; k = j; end
            default: begin nq = qv;            j = 4'h0; k = 4'h0; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and advance the model through its whole lifetime.
    // abort is raised during EXEC cycle abort_at (1-based); 0 means never.
    task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [7:0] count,
                         input int abort_at);
        logic [3:0] nq;
        bit         multi;
        bit         eff;
        int         steps;
        multi = (op == UP) || (op == DOWN) || (op == HOLD);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = d;
        cmd_if.cmd_count = count;
        tick();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = ~d;
        m_ready = 1'b0;
        if (op == NOP || (multi && count == 8'd0)) begin
            m_done = 1'b1;
            m_wrap = 1'b0;
            tick();
            m_done  = 1'b0;
            m_ready = 1'b1;
            return;
        end
        m_busy = 1'b1;
        m_wrap = 1'b0;
        steps  = multi ? int'(count) : 1;
        for (int s = 1; s <= steps; s++) begin
            cmd_if.abort = (s == abort_at);
            eff = multi && (s == abort_at);
            model_step(op, m_q, d, m_j, m_k, nq);
            if (eff) begin
                m_j = 4'h0;
                m_k = 4'h0;
                nq  = m_q;
            end
            tick();
            cmd_if.abort = 1'b0;
            m_wrap = !eff && (((op == UP) && (m_q == 4'hF)) || ((op == DOWN) && (m_q == 4'h0)));
            m_q = nq;
            m_j = 4'h0;
            m_k = 4'h0;
            if (eff || s == steps) break;
        end
        m_busy = 1'b0;
        m_done = 1'b1;
        tick();
        m_done  = 1'b0;
        m_wrap  = 1'b0;
        m_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0;
        logic [3:0] nq;

        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = NOP;
        cmd_if.cmd_data  = 4'h0;
        cmd_if.cmd_count = 8'd0;
        cmd_if.abort     = 1'b0;
        m_q = 4'h0; m_j = 4'h0; m_k = 4'h0;
        m_busy = 1'b0; m_done = 1'b0; m_wrap = 1'b0; m_ready = 1'b0;
        #2;
        check("rst_q", q, 4'h0);
        check("rst_qb", qb, 4'hF);
        check("rst_ready", cmd_if.cmd_ready, 1'b0);
        cmp_en = 1;
        #10;
        rst = 1'b0;
        m_ready = 1'b1;

        // COUNT_UP 5 from 0
        d0 = done_pulses; w0 = wrap_pulses;
        issue(UP, 4'h0, 8'd5, 0);
        check("t1_q", q, 4'h5);
        check("t1_done_cnt", done_pulses - d0, 1);
        check("t1_wrap_cnt", wrap_pulses - w0, 0);

        // LOAD E then COUNT_UP 3 through the wrap
        issue(LOAD, 4'hE, 8'd0, 0);
        check("t2_load", q, 4'hE);
        w0 = wrap_pulses;
        issue(UP, 4'h0, 8'd3, 0);
        check("t2_q", q, 4'h1);
        check("t2_wrap_cnt", wrap_pulses - w0, 1);

        // LOAD 1 then COUNT_DOWN 2 through the wrap
        issue(LOAD, 4'h1, 8'd0, 0);
        w0 = wrap_pulses;
        issue(DOWN, 4'h0, 8'd2, 0);
        check("t3_q", q, 4'hF);
        check("t3_qb", qb, 4'h0);
        check("t3_wrap_cnt", wrap_pulses - w0, 1);

        // SET, TOGGLE 0101 (abort raised but ignored), CLEAR
        d0 = done_pulses;
        issue(SET, 4'h0, 8'd0, 0);
        check("t4_set", q, 4'hF);
        issue(TOGGLE, 4'h5, 8'd0, 1);
        check("t4_toggle", q, 4'hA);
        issue(CLEAR, 4'h0, 8'd0, 0);
        check("t4_clear", q, 4'h0);
        check("t4_done_cnt", done_pulses - d0, 3);

        // HOLD 10 aborted in the 4th EXEC cycle
        issue(LOAD, 4'h6, 8'd0, 0);
        d0 = done_pulses;
        issue(HOLD, 4'h0, 8'd10, 4);
        check("t5_q", q, 4'h6);
        check("t5_done_cnt", done_pulses - d0, 1);

        // NOP and zero-count ops complete immediately without touching q
        d0 = done_pulses;
        issue(NOP, 4'h0, 8'd0, 0);
        issue(DOWN, 4'h0, 8'd0, 0);
        check("t6_q", q, 4'h6);
        check("t6_done_cnt", done_pulses - d0, 2);

        // Async reset during COUNT_UP 200 at q=7
        issue(CLEAR, 4'h0, 8'd0, 0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = UP;
        cmd_if.cmd_count = 8'd200;
        tick();
        cmd_if.cmd_valid = 1'b0;
        m_ready = 1'b0;
        m_busy  = 1'b1;
        for (int s = 0; s < 7; s++) begin
            model_step(UP, m_q, 4'h0, m_j, m_k, nq);
            tick();
            m_q = nq;
        end
        model_step(UP, m_q, 4'h0, m_j, m_k, nq);
        check("t7_pre_q", q, 4'h7);
        #2;
        d0 = done_pulses;
        rst = 1'b1;
        m_q = 4'h0; m_j = 4'h0; m_k = 4'h0;
        m_busy = 1'b0; m_done = 1'b0; m_wrap = 1'b0; m_ready = 1'b0;
        #1;
        check("t7_rst_q", q, 4'h0);
        check("t7_rst_busy", busy, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        issue(LOAD, 4'h3, 8'd0, 0);
        check("t7_load_q", q, 4'h3);
        check("t7_done_cnt", done_pulses - d0, 1);

        repeat (2) tick();
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
